fifo_frame_parser: RTL and testbench

FIFO_FRAME_PARSER -- requirements
Module: fifo_frame_parser

---
 rtl/fifo_frame_parser.sv | 103 ++++++++++
 tb/tb_fifo_frame_parser.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_parser.sv
// Frame parser that sits on a FIFO read port. It hunts for SYNC_BYTE, reads LEN,
// forwards LEN payload bytes through a one-deep output register and checks the XOR checksum.
module fifo_frame_parser #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
  parameter int                    MAX_LEN    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_next,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_ok,
  output logic                  frame_error,
  output logic [7:0]            error_count
);

  localparam int                    CNT_W     = $clog2(MAX_LEN + 1);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] xor_acc;
  logic                  consume;

  // NOTE: read_next is a pure combinational function of registered state and
  // inputs, so the FIFO sees the pop request in the same cycle it presents data.
  always_comb begin
    consume   = (state == PAYLOAD) ? (~out_valid | out_ready) : 1'b1;
    read_next = ~reset & ~read_empty & consume;
  end

  // NOTE: all sequential state uses non-blocking assignments so every branch
  // below sees the pre-edge values of state, count and xor_acc.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= HUNT;
      count       <= '0;
      xor_acc     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_ok    <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      frame_ok    <= 1'b0;
      frame_error <= 1'b0;

      // The output register drains independently of what the parser is doing.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (read_next) begin
        unique case (state)
          HUNT: begin
            if (read_data == SYNC_BYTE) state <= LEN;
          end
          LEN: begin
            xor_acc <= '0;
            if (read_data > MAX_LEN_B) begin
              frame_error <= 1'b1;
              if (error_count != 8'hFF) error_count <= error_count + 8'd1;
              state <= HUNT;
            end else if (read_data == '0) begin
              state <= CHECK;
            end else begin
              count <= CNT_W'(read_data);
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            out_data  <= read_data;
            out_valid <= 1'b1;
            out_last  <= (count == CNT_W'(1));
            xor_acc   <= xor_acc ^ read_data;
            count     <= count - CNT_W'(1);
            if (count == CNT_W'(1)) state <= CHECK;
          end
          CHECK: begin
            if (read_data == xor_acc) begin
              frame_ok <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              if (error_count != 8'hFF) error_count <= error_count + 8'd1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_frame_parser.sv
// Scoreboard bench for fifo_frame_parser: scenarios queue expected bytes and
// frame verdicts, a negedge monitor pops and compares whatever the DUT emits.
module tb_fifo_frame_parser;

  logic       clock = 1'b0;
  logic       reset;
  logic       read_empty;
  logic [7:0] read_data;
  logic       read_next;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_error;
  logic [7:0] error_count;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } out_exp_t;

  out_exp_t out_q[$];
  logic     ev_q[$];     // 1 = frame_ok expected, 0 = frame_error expected
  int       xfer_cyc[$];
  int       cycle = 0;
  int       checks = 0;
  int       errors = 0;

  fifo_frame_parser dut (
    .clock       (clock),
    .reset       (reset),
    .read_empty  (read_empty),
    .read_data   (read_data),
    .read_next   (read_next),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_ok    (frame_ok),
    .frame_error (frame_error),
    .error_count (error_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cycle);
  endtask

  // Monitor: compares every transfer and every frame pulse against the queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          fail_now($sformatf("unexpected_out data=%0h", out_data));
        end else begin
          out_exp_t e;
          e = out_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_last", 32'(out_last), 32'(e.last));
          xfer_cyc.push_back(cycle);
        end
      end
      if (frame_ok || frame_error) begin
        check("pulse_exclusive", 32'(frame_ok & frame_error), 0);
        if (ev_q.size() == 0) fail_now($sformatf("unexpected_pulse ok=%0b err=%0b", frame_ok, frame_error));
        else check("frame_verdict_ok", 32'(frame_ok), 32'(ev_q.pop_front()));
      end
    end
  end

  // Present one byte and hold it until the DUT pops it.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    read_data  = b;
    read_empty = 1'b0;
    n = 0;
    #1;
    while (!read_next && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 100) fail_now($sformatf("pop_timeout byte=%0h", b));
    @(posedge clock);
    #1;
    read_empty = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) send(bytes[i], gap);
  endtask

  task automatic exp_out(input logic [7:0] d, input logic l);
    out_q.push_back('{data: d, last: l});
  endtask

  task automatic drain;
    int n = 0;
    while ((out_q.size() != 0 || ev_q.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) fail_now($sformatf("drain_timeout out_q=%0d ev_q=%0d", out_q.size(), ev_q.size()));
    repeat (2) @(negedge clock);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    read_empty = 1'b0;
    read_data  = 8'hA5;
    out_ready  = 1'b1;

    // Reset with a sync byte waiting at the FIFO head.
    repeat (2) @(negedge clock);
    check("rst_read_next", 32'(read_next), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_pulses", 32'({frame_ok, frame_error}), 0);
    check("rst_error_count", 32'(error_count), 0);
    read_empty = 1'b1;
    reset      = 1'b0;

    // Good frame at full rate.
    xfer_cyc.delete();
    exp_out(8'h11, 1'b0); exp_out(8'h22, 1'b0); exp_out(8'h33, 1'b1);
    ev_q.push_back(1'b1);
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00}, 0);
    drain();
    check("good_xfers", 32'(xfer_cyc.size()), 3);
    if (xfer_cyc.size() == 3) begin
      check("good_consec_1", 32'(xfer_cyc[1] - xfer_cyc[0]), 1);
      check("good_consec_2", 32'(xfer_cyc[2] - xfer_cyc[1]), 1);
    end
    check("good_error_count", 32'(error_count), 0);

    // Bad checksum: payload still forwarded, then an error.
    exp_out(8'h01, 1'b0); exp_out(8'h02, 1'b1);
    ev_q.push_back(1'b0);
    send_frame('{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFF}, 0);
    drain();
    check("badchk_error_count", 32'(error_count), 1);

    // Back-pressure: byte held while the checksum still resolves.
    @(posedge clock); #1 out_ready = 1'b0;
    ev_q.push_back(1'b1);
    exp_out(8'h7E, 1'b1);
    send_frame('{8'hA5, 8'h01, 8'h7E, 8'h7E}, 0);
    repeat (3) @(negedge clock);
    check("bp_ok_seen", 32'(ev_q.size()), 0);
    check("bp_valid_held", 32'(out_valid), 1);
    check("bp_data_held", 32'(out_data), 32'h7E);
    check("bp_last_held", 32'(out_last), 1);
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("bp_valid_dropped", 32'(out_valid), 0);
    drain();

    // Garbage then oversize length: no payload leaves the block.
    ev_q.push_back(1'b0);
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h20}, 0);
    drain();
    check("oversize_error_count", 32'(error_count), 2);
    check("oversize_no_output", 32'(out_valid), 0);

    // Empty frame, then the good frame with an idle cycle between every byte.
    ev_q.push_back(1'b1);
    send_frame('{8'hA5, 8'h00, 8'h00}, 1);
    exp_out(8'h11, 1'b0); exp_out(8'h22, 1'b0); exp_out(8'h33, 1'b1);
    ev_q.push_back(1'b1);
    send_frame('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00}, 1);
    drain();
    check("gaps_error_count", 32'(error_count), 2);

    // Reset mid-frame with a byte stuck in the output register.
    @(posedge clock); #1 out_ready = 1'b0;
    send_frame('{8'hA5, 8'h03, 8'h11}, 0);
    @(negedge clock);
    check("midrst_pre_valid", 32'(out_valid), 1);
    apply_reset(1);
    check("midrst_valid_dropped", 32'(out_valid), 0);
    check("midrst_error_count", 32'(error_count), 0);
    @(posedge clock); #1 out_ready = 1'b1;
    exp_out(8'h5A, 1'b1);
    ev_q.push_back(1'b1);
    send_frame('{8'hA5, 8'h01, 8'h5A, 8'h5A}, 0);
    drain();

    // Saturation of error_count with a burst of oversize frames.
    for (int i = 0; i < 260; i++) begin
      ev_q.push_back(1'b0);
      send_frame('{8'hA5, 8'h10}, 0);
    end
    drain();
    check("sat_error_count", 32'(error_count), 255);
    check("queues_empty", 32'(out_q.size() + ev_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
